// File: rtl/tc_io_input_filter_if.sv
// Pad-side conditioning bundle: raw pad level and filter controls in,
// synchronised/debounced level, edge pulses and interrupt out.
interface tc_io_input_filter_if #(
  parameter int unsigned CNT_W = 16
);
  logic             pad_i;
  logic             en_i;
  logic [CNT_W-1:0] debounce_cycles_i;
  logic             rise_irq_en_i;
  logic             fall_irq_en_i;
  logic             irq_clr_i;
  logic             sync_o;
  logic             level_o;
  logic             rise_o;
  logic             fall_o;
  logic             irq_o;

  modport slave (
    input  pad_i, en_i, debounce_cycles_i, rise_irq_en_i, fall_irq_en_i, irq_clr_i,
    output sync_o, level_o, rise_o, fall_o, irq_o
  );

  modport master (
    output pad_i, en_i, debounce_cycles_i, rise_irq_en_i, fall_irq_en_i, irq_clr_i,
    input  sync_o, level_o, rise_o, fall_o, irq_o
  );
endinterface

// File: rtl/tc_io_input_filter.sv
// Synchronises an asynchronous pad level, debounces it over a programmable
// stability window and produces edge pulses plus a sticky maskable interrupt.
module tc_io_input_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  tc_io_input_filter_if.slave  io
);

  typedef enum logic {MATCH, COUNT} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   irq_q, irq_d;
  logic                   sync_lvl;
  logic                   differ;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], io.pad_i};
  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign differ   = (sync_lvl != level_q);

  // MATCH already evaluates the threshold (cnt is 0 there) so that the level
  // flips after exactly D+1 consecutive differing cycles, giving D=0 the
  // minimum SYNC_STAGES-edge latency.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!io.en_i) begin
      state_d = MATCH;
      cnt_d   = '0;
    end else begin
      case (state_q)
        MATCH: begin
          cnt_d = '0;
          if (differ) begin
            if (io.debounce_cycles_i == '0) begin
              level_d = sync_lvl;
              rise_d  = sync_lvl;
              fall_d  = ~sync_lvl;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = COUNT;
            end
          end
        end
        COUNT: begin
          if (!differ) begin
            cnt_d   = '0;
            state_d = MATCH;
          end else if (cnt_q >= io.debounce_cycles_i) begin
            level_d = sync_lvl;
            rise_d  = sync_lvl;
            fall_d  = ~sync_lvl;
            cnt_d   = '0;
            state_d = MATCH;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = MATCH;
        end
      endcase
    end
  end

  // Set beats clear when both land in the same cycle.
  assign irq_d = (rise_q & io.rise_irq_en_i) | (fall_q & io.fall_irq_en_i) |
                 (irq_q & ~io.irq_clr_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MATCH;
      sync_q  <= {SYNC_STAGES{RESET_VAL}};
      cnt_q   <= '0;
      level_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      irq_q   <= irq_d;
    end
  end

  assign io.sync_o  = sync_lvl;
  assign io.level_o = level_q;
  assign io.rise_o  = rise_q;
  assign io.fall_o  = fall_q;
  assign io.irq_o   = irq_q;

endmodule

// File: tb/tb_tc_io_input_filter.sv
// Cycle-level bench for tc_io_input_filter: vector table plus a mid-count
// reset sequence, expected outputs queued per step and checked after the edge.
module tb_tc_io_input_filter;

  localparam int unsigned CNT_W = 16;

  logic clk;
  logic rst;

  tc_io_input_filter_if #(.CNT_W(CNT_W)) io ();

  tc_io_input_filter #(
    .SYNC_STAGES(2),
    .CNT_W      (CNT_W),
    .RESET_VAL  (1'b0)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .io   (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp bits: {sync, level, rise, fall, irq}
  typedef struct {
    logic             rst;
    logic             en;
    logic             pad;
    logic [CNT_W-1:0] d;
    logic             rie;
    logic             fie;
    logic             clr;
    logic [4:0]       exp;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] sb[$];
  int         total = 0;
  int         bad   = 0;

  function automatic vec_t v(input logic r, input logic en, input logic pad,
                             input int d, input logic rie, input logic fie,
                             input logic clr, input logic [4:0] exp);
    vec_t t;
    t.rst = r; t.en = en; t.pad = pad; t.d = CNT_W'(d);
    t.rie = rie; t.fie = fie; t.clr = clr; t.exp = exp;
    return t;
  endfunction

  task automatic step(input vec_t t, input string name);
    logic [4:0] got;
    logic [4:0] want;
    rst                  = t.rst;
    io.en_i              = t.en;
    io.pad_i             = t.pad;
    io.debounce_cycles_i = t.d;
    io.rise_irq_en_i     = t.rie;
    io.fall_irq_en_i     = t.fie;
    io.irq_clr_i         = t.clr;
    sb.push_back(t.exp);
    @(posedge clk);
    #1;
    got  = {io.sync_o, io.level_o, io.rise_o, io.fall_o, io.irq_o};
    want = sb.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got sync/lvl/rise/fall/irq=%b want %b", name, got, want);
    end
    total++;
    if (io.rise_o === 1'b1 && io.fall_o === 1'b1) begin
      bad++;
      $display("FAIL %s_excl: rise=%b fall=%b both high, want not both", name,
               io.rise_o, io.fall_o);
    end
  endtask

  initial begin
    rst = 1'b1;
    io.en_i = 1'b0; io.pad_i = 1'b0; io.debounce_cycles_i = '0;
    io.rise_irq_en_i = 1'b0; io.fall_irq_en_i = 1'b0; io.irq_clr_i = 1'b0;

    // reset held 2 cycles with pad high, then clean rise with D=3
    vecs.push_back(v(1,1,1,3,1,0,0, 5'b00000));
    vecs.push_back(v(1,1,1,3,1,0,0, 5'b00000));
    vecs.push_back(v(0,1,1,3,1,0,0, 5'b00000));
    vecs.push_back(v(0,1,1,3,1,0,0, 5'b10000));
    vecs.push_back(v(0,1,1,3,1,0,0, 5'b10000));
    vecs.push_back(v(0,1,1,3,1,0,0, 5'b10000));
    vecs.push_back(v(0,1,1,3,1,0,0, 5'b10000));
    vecs.push_back(v(0,1,1,3,1,0,0, 5'b11100));
    vecs.push_back(v(0,1,1,3,1,0,0, 5'b11001));
    vecs.push_back(v(0,1,1,3,1,0,1, 5'b11000));
    // fall with fall mask off
    vecs.push_back(v(0,1,0,3,1,0,0, 5'b11000));
    vecs.push_back(v(0,1,0,3,1,0,0, 5'b01000));
    vecs.push_back(v(0,1,0,3,1,0,0, 5'b01000));
    vecs.push_back(v(0,1,0,3,1,0,0, 5'b01000));
    vecs.push_back(v(0,1,0,3,1,0,0, 5'b01000));
    vecs.push_back(v(0,1,0,3,1,0,0, 5'b00010));
    vecs.push_back(v(0,1,0,3,1,0,0, 5'b00000));
    // 3-cycle glitch, D=3
    vecs.push_back(v(0,1,1,3,1,0,0, 5'b00000));
    vecs.push_back(v(0,1,1,3,1,0,0, 5'b10000));
    vecs.push_back(v(0,1,1,3,1,0,0, 5'b10000));
    vecs.push_back(v(0,1,0,3,1,0,0, 5'b10000));
    vecs.push_back(v(0,1,0,3,1,0,0, 5'b00000));
    vecs.push_back(v(0,1,0,3,1,0,0, 5'b00000));
    vecs.push_back(v(0,1,0,3,1,0,0, 5'b00000));
    // D=0 rise then fall
    vecs.push_back(v(0,1,1,0,1,0,0, 5'b00000));
    vecs.push_back(v(0,1,1,0,1,0,0, 5'b10000));
    vecs.push_back(v(0,1,1,0,1,0,0, 5'b11100));
    vecs.push_back(v(0,1,1,0,1,0,0, 5'b11001));
    vecs.push_back(v(0,1,1,0,1,0,1, 5'b11000));
    vecs.push_back(v(0,1,0,0,1,1,0, 5'b11000));
    vecs.push_back(v(0,1,0,0,1,1,0, 5'b01000));
    vecs.push_back(v(0,1,0,0,1,1,0, 5'b00010));
    vecs.push_back(v(0,1,0,0,1,1,0, 5'b00001));
    // rise with clear held in the setting cycle: set wins, then clear
    vecs.push_back(v(0,1,1,0,1,1,1, 5'b00000));
    vecs.push_back(v(0,1,1,0,1,1,0, 5'b10000));
    vecs.push_back(v(0,1,1,0,1,1,0, 5'b11100));
    vecs.push_back(v(0,1,1,0,1,1,1, 5'b11001));
    vecs.push_back(v(0,1,1,0,1,1,1, 5'b11000));
    // disabled while toggling: level frozen, no pulses
    vecs.push_back(v(0,0,0,0,1,1,0, 5'b11000));
    vecs.push_back(v(0,0,1,0,1,1,0, 5'b01000));
    vecs.push_back(v(0,0,0,0,1,1,0, 5'b11000));
    vecs.push_back(v(0,0,0,0,1,1,0, 5'b01000));
    vecs.push_back(v(0,0,0,0,1,1,0, 5'b01000));
    vecs.push_back(v(0,0,0,0,1,1,0, 5'b01000));
    // re-enable with D=2: counting restarts from 0
    vecs.push_back(v(0,1,0,2,1,1,0, 5'b01000));
    vecs.push_back(v(0,1,0,2,1,1,0, 5'b01000));
    vecs.push_back(v(0,1,0,2,1,1,0, 5'b00010));
    vecs.push_back(v(0,1,0,2,1,1,0, 5'b00001));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // mid-count reset: D=10, reset when cnt has reached 6
    step(v(0,1,0,10,1,0,1, 5'b00000), "mc_clr");
    for (int j = 0; j < 8; j++) begin
      step(v(0,1,1,10,1,0,0, {(j >= 1), 4'b0000}), $sformatf("mc_pre%0d", j));
    end
    step(v(1,1,1,10,1,0,0, 5'b00000), "mc_rst");
    for (int r = 1; r <= 14; r++) begin
      step(v(0,1,1,10,1,0,0, {(r >= 2), (r >= 13), (r == 13), 1'b0, (r == 14)}),
           $sformatf("mc_post%0d", r));
    end

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_drain: got %0d leftover entries, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
